// File: rtl/inst_encode.sv
// Instruction encoder: packs op/register/immediate fields into a 16-bit word
// and writes it to byte-wide program memory, high byte first, at an auto-incrementing pointer.
module inst_encode #(
  parameter logic [3:0] OP_JMP     = 4'b0000,
  parameter logic [3:0] OP_LODI    = 4'b0101,
  parameter int         ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_addr,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  en,
  output logic                  ready,
  input  logic [3:0]            op,
  input  logic [3:0]            reg0,
  input  logic [3:0]            reg1,
  input  logic [3:0]            reg2,
  input  logic [7:0]            imm,
  input  logic                  use_imm,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_data,
  output logic                  mem_we,
  input  logic                  mem_ack,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] wr_ptr
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WR_HI = 2'b01,
    WR_LO = 2'b10
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_TWO  = PTR_ONE + PTR_ONE;

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [7:0]            mem_data_r;
  logic                  mem_we_r;
  logic                  done_r;
  logic                  err_r;
  logic [7:0]            word_lo_r;

  logic [15:0]           word_s;
  logic                  accept_s;
  logic                  reject_s;

  function automatic logic is_wide(input logic [3:0] op_v);
    is_wide = (op_v == OP_JMP) || (op_v == OP_LODI);
  endfunction

  // Decode sign-extends inst[3], so imm[7:3] must be a pure sign extension.
  function automatic logic imm_fits(input logic [4:0] imm_hi);
    imm_fits = (imm_hi == 5'b00000) || (imm_hi == 5'b11111);
  endfunction

  function automatic logic [15:0] pack_word(input logic [3:0] op_v,
                                            input logic [3:0] r0,
                                            input logic [3:0] r1,
                                            input logic [3:0] r2,
                                            input logic [7:0] imm_v,
                                            input logic       ui);
    if (is_wide(op_v)) begin
      pack_word = {op_v, r0, imm_v};
    end else if (ui) begin
      pack_word = {op_v, r0, r1, imm_v[3:0]};
    end else begin
      pack_word = {op_v, r0, r1, r2};
    end
  endfunction

  // Acceptance decision for the current IDLE cycle.
  always_comb begin
    word_s   = pack_word(op, reg0, reg1, reg2, imm, use_imm);
    accept_s = 1'b0;
    reject_s = 1'b0;
    if ((state_r == IDLE) && en && !load_addr) begin
      if (is_wide(op) || !use_imm || imm_fits(imm[7:3])) begin
        accept_s = 1'b1;
      end else begin
        reject_s = 1'b1;
      end
    end else begin
      accept_s = 1'b0;
      reject_s = 1'b0;
    end
  end

  // Write sequencer: IDLE -> high byte -> low byte -> IDLE, with registered memory port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      wr_ptr_r   <= PTR_ZERO;
      mem_addr_r <= PTR_ZERO;
      mem_data_r <= 8'h00;
      mem_we_r   <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      word_lo_r  <= 8'h00;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (load_addr) begin
            wr_ptr_r <= start_addr;
          end else if (accept_s) begin
            word_lo_r  <= word_s[7:0];
            mem_addr_r <= wr_ptr_r;
            mem_data_r <= word_s[15:8];
            mem_we_r   <= 1'b1;
            state_r    <= WR_HI;
          end else if (reject_s) begin
            err_r <= 1'b1;
          end else begin
            mem_we_r <= 1'b0;
          end
        end
        WR_HI: begin
          if (mem_ack) begin
            mem_addr_r <= wr_ptr_r + PTR_ONE;
            mem_data_r <= word_lo_r;
            state_r    <= WR_LO;
          end else begin
            state_r <= WR_HI;
          end
        end
        WR_LO: begin
          if (mem_ack) begin
            mem_we_r <= 1'b0;
            wr_ptr_r <= wr_ptr_r + PTR_TWO;
            done_r   <= 1'b1;
            state_r  <= IDLE;
          end else begin
            state_r <= WR_LO;
          end
        end
        default: begin
          mem_we_r <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign ready    = (state_r == IDLE);
  assign mem_addr = mem_addr_r;
  assign mem_data = mem_data_r;
  assign mem_we   = mem_we_r;
  assign done     = done_r;
  assign err      = err_r;
  assign wr_ptr   = wr_ptr_r;

endmodule

// File: tb/tb_inst_encode.sv
// Self-checking bench for inst_encode: directed scenarios plus randomized
// instructions checked against a field-level reference model.
module tb_inst_encode;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_addr = 1'b0;
  logic [7:0] start_addr = 8'h00;
  logic       en = 1'b0;
  logic       ready;
  logic [3:0] op = 4'h0, reg0 = 4'h0, reg1 = 4'h0, reg2 = 4'h0;
  logic [7:0] imm = 8'h00;
  logic       use_imm = 1'b0;
  logic [7:0] mem_addr, mem_data;
  logic       mem_we;
  logic       mem_ack = 1'b1;
  logic       done, err;
  logic [7:0] wr_ptr;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int wa[$];
  int wd[$];
  int ptr_m = 0;

  inst_encode dut (
    .clk(clk), .rst(rst), .load_addr(load_addr), .start_addr(start_addr),
    .en(en), .ready(ready), .op(op), .reg0(reg0), .reg1(reg1), .reg2(reg2),
    .imm(imm), .use_imm(use_imm), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .mem_ack(mem_ack), .done(done), .err(err), .wr_ptr(wr_ptr)
  );

  always #5 clk = ~clk;

  // Memory-side monitor: inputs change just after posedge, so negedge sees what the DUT samples next.
  always @(negedge clk) begin
    if (!rst && mem_we && mem_ack) begin
      wa.push_back(int'(mem_addr));
      wd.push_back(int'(mem_data));
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done || err) begin
      checks++;
      if (done && err) begin
        errors++;
        $display("FAIL done_err_exclusive: done=%0b err=%0b, required not both high", done, err);
      end
    end
  end

  // Reference model: the 16-bit word from the field rules, or -1 when the range check rejects it.
  function automatic int model_word(int o, int r0, int r1, int r2, int im, int ui);
    bit wide = (o == 0) || (o == 5);
    if (wide) return o * 4096 + r0 * 256 + im;
    if (ui == 0) return o * 4096 + r0 * 256 + r1 * 16 + r2;
    if (im > 7 && im < 248) return -1;
    return o * 4096 + r0 * 256 + r1 * 16 + (im % 16);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  task automatic issue(int o, int r0, int r1, int r2, int im, int ui);
    op = 4'(o); reg0 = 4'(r0); reg1 = 4'(r1); reg2 = 4'(r2);
    imm = 8'(im); use_imm = ui[0];
    en = 1'b1;
    step();
    en = 1'b0;
  endtask

  // Wait (bounded) until the DUT is idle again, then one more cycle so done/err are logged.
  task automatic finish_op(bit rand_ack, output bit timed_out);
    int n = 0;
    while (!ready && n < 200) begin
      if (rand_ack) mem_ack = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    timed_out = !ready;
    mem_ack = 1'b1;
    step();
  endtask

  task automatic load_ptr(int a);
    start_addr = 8'(a);
    load_addr = 1'b1;
    step();
    load_addr = 1'b0;
    ptr_m = a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({mem_we, done, err, ready} !== 4'b0001 || mem_addr !== 8'h00 || mem_data !== 8'h00 || wr_ptr !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: we=%0b done=%0b err=%0b ready=%0b addr=%h data=%h ptr=%h, required 0/0/0/1/00/00/00",
               mem_we, done, err, ready, mem_addr, mem_data, wr_ptr);
    end
    rst = 1'b0;
    ptr_m = 0;
    step();
  endtask

  task automatic test_wide();
    bit to;
    int d0;
    load_ptr(8'h10);
    clear_log();
    d0 = done_cnt;
    mem_ack = 1'b1;
    issue(5, 3, 0, 0, 8'hA7, 0);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_data !== 8'h53) begin
      errors++;
      $display("FAIL wide_latency: we=%0b addr=%h data=%h one cycle after accept, required 1/10/53", mem_we, mem_addr, mem_data);
    end
    finish_op(1'b0, to);
    checks++;
    if (to || wa.size() != 2 || wa[0] != 8'h10 || wd[0] != 8'h53 || wa[1] != 8'h11 || wd[1] != 8'hA7) begin
      errors++;
      $display("FAIL wide_writes: count=%0d first=%h@%h second=%h@%h, required 53@10 A7@11",
               wa.size(), wd.size() > 0 ? wd[0] : -1, wa.size() > 0 ? wa[0] : -1,
               wd.size() > 1 ? wd[1] : -1, wa.size() > 1 ? wa[1] : -1);
    end
    checks++;
    if (done_cnt - d0 != 1 || wr_ptr !== 8'h12) begin
      errors++;
      $display("FAIL wide_done_ptr: done pulses=%0d ptr=%h, required 1 and 12", done_cnt - d0, wr_ptr);
    end
    ptr_m = 8'h12;
  endtask

  task automatic test_register();
    bit to;
    clear_log();
    issue(2, 1, 2, 4'hF, 8'h00, 0);
    finish_op(1'b0, to);
    checks++;
    if (to || wd.size() != 2 || wd[0] != 8'h21 || wd[1] != 8'h2F || wa[0] != 8'h12) begin
      errors++;
      $display("FAIL reg_op_reg2: count=%0d bytes=%h,%h, required 21,2F @12",
               wd.size(), wd.size() > 0 ? wd[0] : -1, wd.size() > 1 ? wd[1] : -1);
    end
    clear_log();
    issue(2, 1, 2, 4'hF, 8'hFD, 1);
    finish_op(1'b0, to);
    checks++;
    if (to || wd.size() != 2 || wd[0] != 8'h21 || wd[1] != 8'h2D || wa[1] != 8'h15) begin
      errors++;
      $display("FAIL reg_op_imm: count=%0d bytes=%h,%h, required 21,2D ending @15",
               wd.size(), wd.size() > 0 ? wd[0] : -1, wd.size() > 1 ? wd[1] : -1);
    end
    ptr_m = 8'h16;
  endtask

  task automatic test_range_error();
    bit to;
    int e0, d0;
    clear_log();
    e0 = err_cnt;
    d0 = done_cnt;
    issue(2, 1, 2, 0, 8'h08, 1);
    checks++;
    if (err !== 1'b1 || mem_we !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL range_err_pulse: err=%0b we=%0b ready=%0b, required 1/0/1", err, mem_we, ready);
    end
    finish_op(1'b0, to);
    checks++;
    if (err_cnt - e0 != 1 || wa.size() != 0 || done_cnt != d0 || wr_ptr !== 8'(ptr_m)) begin
      errors++;
      $display("FAIL range_err_effect: err pulses=%0d writes=%0d done=%0d ptr=%h, required 1/0/0/%h",
               err_cnt - e0, wa.size(), done_cnt - d0, wr_ptr, ptr_m);
    end
    clear_log();
    issue(0, 1, 2, 0, 8'h08, 1);
    finish_op(1'b0, to);
    checks++;
    if (to || wd.size() != 2 || wd[0] != 8'h01 || wd[1] != 8'h08 || err_cnt - e0 != 1) begin
      errors++;
      $display("FAIL range_jmp_ok: count=%0d bytes=%h,%h errs=%0d, required 01,08 with no new err",
               wd.size(), wd.size() > 0 ? wd[0] : -1, wd.size() > 1 ? wd[1] : -1, err_cnt - e0);
    end
    ptr_m = (ptr_m + 2) % 256;
  endtask

  task automatic test_backpressure();
    bit to;
    int d0;
    clear_log();
    d0 = done_cnt;
    mem_ack = 1'b0;
    issue(7, 4'hA, 4'hB, 4'hC, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        op = 4'h9; reg0 = 4'h1; en = 1'b1;
      end
      checks++;
      if (mem_we !== 1'b1 || ready !== 1'b0 || mem_addr !== 8'(ptr_m) || mem_data !== 8'h7A) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: we=%0b ready=%0b addr=%h data=%h, required 1/0/%h/7A",
                 i, mem_we, ready, mem_addr, mem_data, ptr_m);
      end
      step();
    end
    en = 1'b0;
    mem_ack = 1'b1;
    finish_op(1'b0, to);
    checks++;
    if (to || wd.size() != 2 || wd[0] != 8'h7A || wd[1] != 8'hBC || done_cnt - d0 != 1 || wr_ptr !== 8'((ptr_m + 2) % 256)) begin
      errors++;
      $display("FAIL backpressure_complete: count=%0d bytes=%h,%h done=%0d ptr=%h, required 7A,BC one done",
               wd.size(), wd.size() > 0 ? wd[0] : -1, wd.size() > 1 ? wd[1] : -1, done_cnt - d0, wr_ptr);
    end
    ptr_m = (ptr_m + 2) % 256;
  endtask

  task automatic test_wrap_priority();
    bit to;
    int d0;
    load_ptr(8'hFF);
    clear_log();
    issue(3, 4, 5, 6, 0, 0);
    finish_op(1'b0, to);
    checks++;
    if (to || wa.size() != 2 || wa[0] != 8'hFF || wa[1] != 8'h00 || wd[0] != 8'h34 || wd[1] != 8'h56 || wr_ptr !== 8'h01) begin
      errors++;
      $display("FAIL wrap: count=%0d addrs=%h,%h ptr=%h, required FF,00 and ptr 01",
               wa.size(), wa.size() > 0 ? wa[0] : -1, wa.size() > 1 ? wa[1] : -1, wr_ptr);
    end
    clear_log();
    d0 = done_cnt;
    start_addr = 8'h40;
    load_addr = 1'b1;
    en = 1'b1;
    step();
    load_addr = 1'b0;
    en = 1'b0;
    step();
    step();
    step();
    checks++;
    if (wr_ptr !== 8'h40 || wa.size() != 0 || mem_we !== 1'b0 || done_cnt != d0) begin
      errors++;
      $display("FAIL load_priority: ptr=%h writes=%0d we=%0b done=%0d, required 40/0/0/0",
               wr_ptr, wa.size(), mem_we, done_cnt - d0);
    end
    ptr_m = 8'h40;
  endtask

  task automatic test_random();
    bit to;
    int o, r0, r1, r2, im, ui, w, e0, d0, bad;
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      o = $urandom_range(0, 15); r0 = $urandom_range(0, 15);
      r1 = $urandom_range(0, 15); r2 = $urandom_range(0, 15);
      im = $urandom_range(0, 255); ui = $urandom_range(0, 1);
      w = model_word(o, r0, r1, r2, im, ui);
      clear_log();
      e0 = err_cnt;
      d0 = done_cnt;
      issue(o, r0, r1, r2, im, ui);
      finish_op(1'b1, to);
      checks++;
      if (w < 0) begin
        if (to || wa.size() != 0 || err_cnt - e0 != 1 || done_cnt != d0 || wr_ptr !== 8'(ptr_m)) begin
          errors++; bad++;
          $display("FAIL random_reject[%0d]: op=%h imm=%h writes=%0d errs=%0d ptr=%h, required 0 writes 1 err ptr %h",
                   n, o, im, wa.size(), err_cnt - e0, wr_ptr, ptr_m);
        end
      end else begin
        if (to || wa.size() != 2 || wa[0] != ptr_m || wd[0] != w / 256 || wa[1] != (ptr_m + 1) % 256 ||
            wd[1] != w % 256 || done_cnt - d0 != 1 || err_cnt != e0 || wr_ptr !== 8'((ptr_m + 2) % 256)) begin
          errors++; bad++;
          $display("FAIL random_write[%0d]: op=%h count=%0d first=%h second=%h ptr=%h, required word %h @%h",
                   n, o, wa.size(), wd.size() > 0 ? wd[0] : -1, wd.size() > 1 ? wd[1] : -1, wr_ptr, w, ptr_m);
        end
        ptr_m = (ptr_m + 2) % 256;
      end
      if (bad > 5) break;
    end
  endtask

  task automatic test_reset_midop();
    int d0;
    clear_log();
    mem_ack = 1'b1;
    issue(2, 1, 1, 1, 0, 0);
    step();
    mem_ack = 1'b0;
    d0 = done_cnt;
    checks++;
    if (mem_we !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL midop_setup: we=%0b ready=%0b in low-byte phase, required 1/0", mem_we, ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0 || ready !== 1'b1 || wr_ptr !== 8'h00) begin
      errors++;
      $display("FAIL midop_async_reset: we=%0b ready=%0b ptr=%h, required 0/1/00", mem_we, ready, wr_ptr);
    end
    step();
    rst = 1'b0;
    mem_ack = 1'b1;
    step();
    step();
    checks++;
    if (done_cnt != d0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL midop_no_done: done pulses=%0d we=%0b, required 0/0", done_cnt - d0, mem_we);
    end
  endtask

  initial begin
    step();
    test_reset();
    test_wide();
    test_register();
    test_range_error();
    test_backpressure();
    test_wrap_priority();
    test_random();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
